// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for a weight-stationary systolic array: weight load, ifmap stream, ofmap write/accumulate.
// Optional cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_tile_ctrl #(
   parameter int MAC_ROW           = 16,
   parameter int MAC_COL           = 16,
   parameter int W_ADDR_BIT        = 11,
   parameter int IFMAP_ADDR_BIT    = 9,
   parameter int OFMAP_ADDR_BIT    = 10,
   parameter int OFMAP_CAHNNEL_NUM = 64,
   parameter int IFMAP_CAHNNEL_NUM = 32,
   parameter int WEIGHT_WIDTH      = 3,
   parameter int WEIGHT_HEIGHT     = 3,
   parameter int IFMAP_WIDTH       = 16,
   parameter int IFMAP_HEIGHT      = 16,
   parameter int OFMAP_WIDTH       = 14,
   parameter int OFMAP_HEIGHT      = 14,
   parameter int PIPE_LAT          = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start_in,
   output logic                      finish_out,
   output logic                      busy_out,
   output logic                      w_rd_en_out,
   output logic [W_ADDR_BIT-1:0]     w_addr_out,
   output logic                      w_shift_out,
   output logic                      if_rd_en_out,
   output logic [IFMAP_ADDR_BIT-1:0] if_addr_out,
   output logic                      if_valid_out,
   output logic                      of_wr_en_out,
   output logic                      of_acc_out,
   output logic [OFMAP_ADDR_BIT-1:0] of_addr_out,
   output logic [31:0]               perf_cycles_out
);

   localparam int OCG     = OFMAP_CAHNNEL_NUM / MAC_COL;
   localparam int ICG     = IFMAP_CAHNNEL_NUM / MAC_ROW;
   localparam int NPIX    = OFMAP_WIDTH * OFMAP_HEIGHT;
   localparam int DL      = PIPE_LAT + 1;
   localparam int CNT_MAX = (MAC_ROW > PIPE_LAT) ? MAC_ROW : PIPE_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int OCG_W   = $clog2(OCG + 1);
   localparam int ICG_W   = $clog2(ICG + 1);
   localparam int KX_W    = $clog2(WEIGHT_WIDTH + 1);
   localparam int KY_W    = $clog2(WEIGHT_HEIGHT + 1);
   localparam int OX_W    = $clog2(OFMAP_WIDTH + 1);
   localparam int OY_W    = $clog2(OFMAP_HEIGHT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [CNT_W-1:0] r_cnt;
   logic [OCG_W-1:0] r_ocg;
   logic [ICG_W-1:0] r_icg;
   logic [KY_W-1:0]  r_ky;
   logic [KX_W-1:0]  r_kx;
   logic [OY_W-1:0]  r_oy;
   logic [OX_W-1:0]  r_ox;

   logic w_start_acc;
   logic w_load_last;
   logic w_pix_last;
   logic w_drain_last;
   logic w_tile_last;
   logic w_kx_last;
   logic w_ky_last;
   logic w_icg_last;
   logic w_ocg_last;

   logic [31:0]               w_tile;
   logic [W_ADDR_BIT-1:0]     w_w_addr;
   logic [IFMAP_ADDR_BIT-1:0] w_if_addr;
   logic [OFMAP_ADDR_BIT-1:0] w_of_addr;
   logic                      w_acc;

   assign w_start_acc  = start_in && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_load_last  = (r_cnt == CNT_W'(MAC_ROW - 1));
   assign w_drain_last = (r_cnt == CNT_W'(PIPE_LAT - 1));
   assign w_pix_last   = (r_ox == OX_W'(OFMAP_WIDTH - 1)) && (r_oy == OY_W'(OFMAP_HEIGHT - 1));
   assign w_kx_last    = (r_kx == KX_W'(WEIGHT_WIDTH - 1));
   assign w_ky_last    = (r_ky == KY_W'(WEIGHT_HEIGHT - 1));
   assign w_icg_last   = (r_icg == ICG_W'(ICG - 1));
   assign w_ocg_last   = (r_ocg == OCG_W'(OCG - 1));
   assign w_tile_last  = w_kx_last && w_ky_last && w_icg_last && w_ocg_last;

   // Address generation from the loop indices; all products fit the port widths at the defaults.
   assign w_tile    = ((32'(r_ocg) * ICG + 32'(r_icg)) * WEIGHT_HEIGHT + 32'(r_ky)) * WEIGHT_WIDTH
                      + 32'(r_kx);
   assign w_w_addr  = W_ADDR_BIT'(w_tile * MAC_ROW + 32'(r_cnt));
   assign w_if_addr = IFMAP_ADDR_BIT'(32'(r_icg) * (IFMAP_WIDTH * IFMAP_HEIGHT)
                      + (32'(r_oy) + 32'(r_ky)) * IFMAP_WIDTH + 32'(r_ox) + 32'(r_kx));
   assign w_of_addr = OFMAP_ADDR_BIT'(32'(r_ocg) * NPIX + 32'(r_oy) * OFMAP_WIDTH + 32'(r_ox));
   assign w_acc     = !((r_icg == '0) && (r_ky == '0) && (r_kx == '0));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start_in) w_state_next = S_LOAD_W;
         S_LOAD_W:       if (w_load_last) w_state_next = S_STREAM;
         S_STREAM:       if (w_pix_last) w_state_next = S_DRAIN;
         S_DRAIN:        if (w_drain_last) w_state_next = w_tile_last ? S_DONE : S_LOAD_W;
         default:        w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy_out     = 1'b0;
      finish_out   = 1'b0;
      w_rd_en_out  = 1'b0;
      w_addr_out   = '0;
      if_rd_en_out = 1'b0;
      if_addr_out  = '0;
      case (r_state)
         S_LOAD_W: begin
            busy_out    = 1'b1;
            w_rd_en_out = 1'b1;
            w_addr_out  = w_w_addr;
         end
         S_STREAM: begin
            busy_out     = 1'b1;
            if_rd_en_out = 1'b1;
            if_addr_out  = w_if_addr;
         end
         S_DRAIN:  busy_out   = 1'b1;
         S_DONE:   finish_out = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
         r_ocg <= '0;
         r_icg <= '0;
         r_ky  <= '0;
         r_kx  <= '0;
         r_oy  <= '0;
         r_ox  <= '0;
      end else if (w_start_acc) begin
         r_cnt <= '0;
         r_ocg <= '0;
         r_icg <= '0;
         r_ky  <= '0;
         r_kx  <= '0;
         r_oy  <= '0;
         r_ox  <= '0;
      end else begin
         case (r_state)
            S_LOAD_W: r_cnt <= w_load_last ? '0 : r_cnt + CNT_W'(1);
            S_STREAM: begin
               if (r_ox == OX_W'(OFMAP_WIDTH - 1)) begin
                  r_ox <= '0;
                  r_oy <= (r_oy == OY_W'(OFMAP_HEIGHT - 1)) ? '0 : r_oy + OY_W'(1);
               end else begin
                  r_ox <= r_ox + OX_W'(1);
               end
            end
            S_DRAIN: begin
               if (w_drain_last) begin
                  r_cnt <= '0;
                  // kx fastest, then ky, icg, ocg
                  if (w_kx_last) begin
                     r_kx <= '0;
                     if (w_ky_last) begin
                        r_ky <= '0;
                        if (w_icg_last) begin
                           r_icg <= '0;
                           r_ocg <= w_ocg_last ? '0 : r_ocg + OCG_W'(1);
                        end else begin
                           r_icg <= r_icg + ICG_W'(1);
                        end
                     end else begin
                        r_ky <= r_ky + KY_W'(1);
                     end
                  end else begin
                     r_kx <= r_kx + KX_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   logic r_w_shift;
   logic r_if_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_w_shift  <= 1'b0;
         r_if_valid <= 1'b0;
      end else begin
         r_w_shift  <= w_rd_en_out;
         r_if_valid <= if_rd_en_out;
      end
   end

   assign w_shift_out  = r_w_shift;
   assign if_valid_out = r_if_valid;

   // Ofmap delay line: the tail lines up each write with the array output of its ifmap read.
   logic [DL-1:0]             r_dl_valid;
   logic [DL-1:0]             r_dl_acc;
   logic [OFMAP_ADDR_BIT-1:0] r_dl_addr [0:DL-1];
   logic                      w_dl_valid_in;

   assign w_dl_valid_in = (r_state == S_STREAM);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_dl_valid <= '0;
         r_dl_acc   <= '0;
         for (int i = 0; i < DL; i++) begin
            r_dl_addr[i] <= '0;
         end
      end else begin
         r_dl_valid   <= {r_dl_valid[DL-2:0], w_dl_valid_in};
         r_dl_acc     <= {r_dl_acc[DL-2:0], w_dl_valid_in && w_acc};
         r_dl_addr[0] <= w_dl_valid_in ? w_of_addr : '0;
         for (int i = 1; i < DL; i++) begin
            r_dl_addr[i] <= r_dl_addr[i-1];
         end
      end
   end

   assign of_wr_en_out = r_dl_valid[DL-1];
   assign of_acc_out   = r_dl_acc[DL-1];
   assign of_addr_out  = r_dl_addr[DL-1];

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_perf <= '0;
      end else if (w_start_acc) begin
         r_perf <= '0;
      end else if (busy_out) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_cycles_out = r_perf;
`else
   assign perf_cycles_out = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Self-checking bench for systolic_tile_ctrl: vector table, spec-level cycle model, reset and start-ignore sequences.
`timescale 1ns/1ps
module tb_systolic_tile_ctrl;

   localparam int W_ADDR_BIT     = 11;
   localparam int IFMAP_ADDR_BIT = 9;
   localparam int OFMAP_ADDR_BIT = 10;
   localparam int NROW     = 16;
   localparam int NPIX     = 196;
   localparam int OW       = 14;
   localparam int IW       = 16;
   localparam int IPLANE   = 256;
   localparam int LAT      = 32;
   localparam int TILE_CYC = NROW + NPIX + LAT;  // 244
   localparam int NTILE    = 72;
   localparam int RUN_BUSY = NTILE * TILE_CYC;   // 17568
   localparam int NREC     = RUN_BUSY + 1 + 40;
   localparam int NWRITES  = NTILE * NPIX;

   localparam int SIG_BUSY = 0, SIG_FIN = 1, SIG_WEN = 2, SIG_WADDR = 3, SIG_WSH = 4, SIG_IFEN = 5,
                  SIG_IFADDR = 6, SIG_IFV = 7, SIG_OFWR = 8, SIG_OFACC = 9, SIG_OFADDR = 10;

   logic                      clk = 1'b0;
   logic                      rstn = 1'b0;
   logic                      start_in = 1'b0;
   logic                      finish_out, busy_out, w_rd_en_out, w_shift_out;
   logic                      if_rd_en_out, if_valid_out, of_wr_en_out, of_acc_out;
   logic [W_ADDR_BIT-1:0]     w_addr_out;
   logic [IFMAP_ADDR_BIT-1:0] if_addr_out;
   logic [OFMAP_ADDR_BIT-1:0] of_addr_out;
   logic [31:0]               perf_cycles_out;

   systolic_tile_ctrl dut (
      .clk(clk), .rstn(rstn), .start_in(start_in),
      .finish_out(finish_out), .busy_out(busy_out),
      .w_rd_en_out(w_rd_en_out), .w_addr_out(w_addr_out), .w_shift_out(w_shift_out),
      .if_rd_en_out(if_rd_en_out), .if_addr_out(if_addr_out), .if_valid_out(if_valid_out),
      .of_wr_en_out(of_wr_en_out), .of_acc_out(of_acc_out), .of_addr_out(of_addr_out),
      .perf_cycles_out(perf_cycles_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic busy, finish, w_en, w_shift, if_en, if_valid, of_wr, of_acc;
      int   w_addr, if_addr, of_addr, perf;
   } obs_t;

   typedef struct {
      string name;
      int    cyc;
      int    sig;
      int    exp;
   } vec_t;

   obs_t rec [0:NREC];
   bit   pulse_at [0:NREC];
   int   n_chk = 0, n_pass = 0;
   int   g_mism [5], g_cyc [5], g_got [5], g_exp [5];
   string g_name [5] = '{"ctrl", "weight", "ifmap", "ofmap", "perf"};

   function automatic obs_t sample();
      obs_t o;
      o.busy = busy_out;          o.finish = finish_out;
      o.w_en = w_rd_en_out;       o.w_shift = w_shift_out;
      o.if_en = if_rd_en_out;     o.if_valid = if_valid_out;
      o.of_wr = of_wr_en_out;     o.of_acc = of_acc_out;
      o.w_addr = int'(w_addr_out); o.if_addr = int'(if_addr_out);
      o.of_addr = int'(of_addr_out); o.perf = int'(perf_cycles_out);
      return o;
   endfunction

   // Weight read in cycle c (cycle 1 = first cycle after start is sampled)?
   function automatic void wrd(input int c, output bit en, output int addr);
      int ph;
      en = 0; addr = 0;
      if (c < 1 || c > RUN_BUSY) return;
      ph = (c - 1) % TILE_CYC;
      if (ph < NROW) begin
         en = 1; addr = ((c - 1) / TILE_CYC) * NROW + ph;
      end
   endfunction

   // Ifmap read in cycle c, with its ofmap destination.
   function automatic void pix(input int c, output bit en, output int ifa, output int ofa, output bit acc);
      int tile, ph, p, kx, ky, icg, ocg;
      en = 0; ifa = 0; ofa = 0; acc = 0;
      if (c < 1 || c > RUN_BUSY) return;
      tile = (c - 1) / TILE_CYC;
      ph   = (c - 1) % TILE_CYC;
      if (ph < NROW || ph >= NROW + NPIX) return;
      p   = ph - NROW;
      kx  = tile % 3;
      ky  = (tile / 3) % 3;
      icg = (tile / 9) % 2;
      ocg = tile / 18;
      en  = 1;
      ifa = icg * IPLANE + (p / OW + ky) * IW + (p % OW) + kx;
      ofa = ocg * NPIX + p;
      acc = !(icg == 0 && ky == 0 && kx == 0);
   endfunction

   function automatic obs_t model(input int c);
      obs_t e;
      bit en, acc; int a, b;
      e = '0;
      e.busy   = (c >= 1 && c <= RUN_BUSY);
      e.finish = (c > RUN_BUSY);
      wrd(c, en, a);         e.w_en = en; e.w_addr = a;
      wrd(c - 1, en, a);     e.w_shift = en;
      pix(c, en, a, b, acc); e.if_en = en; e.if_addr = a;
      pix(c - 1, en, a, b, acc); e.if_valid = en;
      pix(c - LAT - 1, en, a, b, acc); e.of_wr = en; e.of_addr = b; e.of_acc = acc;
`ifdef SYSTOLIC_CTRL_PERF_EN
      e.perf = (c - 1 < RUN_BUSY) ? c - 1 : RUN_BUSY;
`else
      e.perf = 0;
`endif
      return e;
   endfunction

   function automatic int pick(input obs_t o, input int sig);
      case (sig)
         SIG_BUSY:   return int'(o.busy);
         SIG_FIN:    return int'(o.finish);
         SIG_WEN:    return int'(o.w_en);
         SIG_WADDR:  return o.w_addr;
         SIG_WSH:    return int'(o.w_shift);
         SIG_IFEN:   return int'(o.if_en);
         SIG_IFADDR: return o.if_addr;
         SIG_IFV:    return int'(o.if_valid);
         SIG_OFWR:   return int'(o.of_wr);
         SIG_OFACC:  return int'(o.of_acc);
         default:    return o.of_addr;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) begin
         n_pass++;
         $display("ok   %s = %0d", nm, act);
      end else begin
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic note(input int g, input int c, input int got, input int exp);
      if (got != exp) begin
         if (g_mism[g] == 0) begin
            g_cyc[g] = c; g_got[g] = got; g_exp[g] = exp;
         end
         g_mism[g]++;
      end
   endtask

   task automatic check_run(input string name);
      obs_t e, a;
      int wr_cnt = 0;
      for (int g = 0; g < 5; g++) g_mism[g] = 0;
      for (int c = 1; c <= NREC; c++) begin
         e = model(c);
         a = rec[c];
         note(0, c, int'(a.busy), int'(e.busy));
         note(0, c, int'(a.finish), int'(e.finish));
         note(1, c, int'(a.w_en), int'(e.w_en));
         note(1, c, int'(a.w_shift), int'(e.w_shift));
         if (e.w_en) note(1, c, a.w_addr, e.w_addr);
         note(2, c, int'(a.if_en), int'(e.if_en));
         note(2, c, int'(a.if_valid), int'(e.if_valid));
         if (e.if_en) note(2, c, a.if_addr, e.if_addr);
         note(3, c, int'(a.of_wr), int'(e.of_wr));
         if (e.of_wr) begin
            note(3, c, a.of_addr, e.of_addr);
            note(3, c, int'(a.of_acc), int'(e.of_acc));
         end
         note(4, c, a.perf, e.perf);
         wr_cnt += int'(a.of_wr);
      end
      for (int g = 0; g < 5; g++) begin
         n_chk++;
         if (g_mism[g] == 0) begin
            n_pass++;
            $display("ok   %s_%s model match over %0d cycles", name, g_name[g], NREC);
         end else begin
            $display("FAIL %s_%s: %0d cycles differ, first at cycle %0d got %0d expected %0d",
                     name, g_name[g], g_mism[g], g_cyc[g], g_got[g], g_exp[g]);
         end
      end
      chk({name, "_write_count"}, wr_cnt, NWRITES);
   endtask

   // Start is driven before the sampling edge; rec[c] is taken at the falling edge of cycle c.
   task automatic run_capture(input bit with_pulses);
      start_in = 1'b1;
      for (int c = 1; c <= NREC; c++) begin
         @(negedge clk);
         rec[c] = sample();
         start_in = with_pulses && pulse_at[c];
      end
      start_in = 1'b0;
   endtask

   vec_t vecs[$];
   int   zero_bad;
   obs_t o;

   initial begin
      vecs.push_back('{"busy_c1",        1,     SIG_BUSY,   1});
      vecs.push_back('{"finish_c1",      1,     SIG_FIN,    0});
      vecs.push_back('{"w_en_c1",        1,     SIG_WEN,    1});
      vecs.push_back('{"w_addr_c1",      1,     SIG_WADDR,  0});
      vecs.push_back('{"w_addr_c16",     16,    SIG_WADDR,  15});
      vecs.push_back('{"w_shift_c1",     1,     SIG_WSH,    0});
      vecs.push_back('{"w_shift_c17",    17,    SIG_WSH,    1});
      vecs.push_back('{"w_en_c17",       17,    SIG_WEN,    0});
      vecs.push_back('{"if_en_c17",      17,    SIG_IFEN,   1});
      vecs.push_back('{"if_addr_c17",    17,    SIG_IFADDR, 0});
      vecs.push_back('{"if_addr_c30",    30,    SIG_IFADDR, 13});
      vecs.push_back('{"if_addr_c31",    31,    SIG_IFADDR, 16});
      vecs.push_back('{"if_valid_c17",   17,    SIG_IFV,    0});
      vecs.push_back('{"if_valid_c18",   18,    SIG_IFV,    1});
      vecs.push_back('{"of_wr_c49",      49,    SIG_OFWR,   0});
      vecs.push_back('{"of_wr_c50",      50,    SIG_OFWR,   1});
      vecs.push_back('{"of_addr_c50",    50,    SIG_OFADDR, 0});
      vecs.push_back('{"of_acc_c50",     50,    SIG_OFACC,  0});
      vecs.push_back('{"t1_if_addr",     261,   SIG_IFADDR, 1});
      vecs.push_back('{"t1_of_wr",       294,   SIG_OFWR,   1});
      vecs.push_back('{"t1_of_acc",      294,   SIG_OFACC,  1});
      vecs.push_back('{"ocg1_of_addr",   4442,  SIG_OFADDR, 196});
      vecs.push_back('{"ocg1_of_acc",    4442,  SIG_OFACC,  0});
      vecs.push_back('{"busy_c17568",    17568, SIG_BUSY,   1});
      vecs.push_back('{"finish_c17568",  17568, SIG_FIN,    0});
      vecs.push_back('{"finish_c17569",  17569, SIG_FIN,    1});
      vecs.push_back('{"busy_c17569",    17569, SIG_BUSY,   0});
      vecs.push_back('{"last_of_wr",     17569, SIG_OFWR,   1});
      vecs.push_back('{"last_of_addr",   17569, SIG_OFADDR, 783});
      vecs.push_back('{"of_wr_c17570",   17570, SIG_OFWR,   0});

      // Power-on reset, then idle
      zero_bad = 0;
      repeat (3) begin
         @(negedge clk);
         o = sample();
         if (o != '0) zero_bad++;
      end
      rstn = 1'b1;
      repeat (2) begin
         @(negedge clk);
         o = sample();
         if (o != '0) zero_bad++;
      end
      chk("reset_idle_nonzero_samples", zero_bad, 0);

      // Run A: clean run, table vectors and full model
      run_capture(1'b0);
      foreach (vecs[i]) chk(vecs[i].name, pick(rec[vecs[i].cyc], vecs[i].sig), vecs[i].exp);
      check_run("runA");

      // Run B: restart from DONE with random start pulses while busy
      for (int c = 0; c <= NREC; c++) pulse_at[c] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         int pc = int'($urandom_range(2, 17500));
         pulse_at[pc] = 1'b1;
         $display("runB start pulse at cycle %0d", pc);
      end
      run_capture(1'b1);
      check_run("runB");

      // Run C: aborted by reset at cycle 5000 for 3 cycles
      start_in = 1'b1;
      for (int c = 1; c <= 5000; c++) begin
         @(negedge clk);
         start_in = 1'b0;
      end
      chk("runC_busy_before_reset", int'(busy_out), 1);
      rstn = 1'b0;
      #1;
      zero_bad = 0;
      o = sample();
      if (o != '0) zero_bad++;
      repeat (3) begin
         @(negedge clk);
         o = sample();
         if (o != '0) zero_bad++;
      end
      rstn = 1'b1;
      @(negedge clk);
      o = sample();
      if (o != '0) zero_bad++;
      chk("runC_reset_nonzero_samples", zero_bad, 0);

      // Run D: fresh run after the abort
      run_capture(1'b0);
      check_run("runD");
      chk("runD_first_w_addr", rec[1].w_addr, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
      chk("runD_perf_final", rec[NREC].perf, RUN_BUSY);
`else
      chk("runD_perf_final", rec[NREC].perf, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
